// File: rtl/fet_queue_pkg.sv
// Shared fetch-queue types: the per-slot fetch bundle and the default queue depth.
package fet_queue_pkg;
    localparam int FETQ_DEPTH = 16;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } fet_bundle_t;
endpackage

// File: rtl/fet_compact.sv
// Prefix popcount over fetch slot valids: per-slot destination offset plus total; purely combinational.
module fet_compact #(
    parameter int WIDTH = 4,
    parameter int OFF_W = $clog2(WIDTH),
    parameter int TOT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]            i_valid,
    output logic [WIDTH-1:0][OFF_W-1:0] o_offset,
    output logic [TOT_W-1:0]            o_total
);
    logic [TOT_W-1:0] w_run;

    always_comb begin
        w_run = '0;
        o_offset = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_offset[i] = w_run[OFF_W-1:0];
            w_run = w_run + TOT_W'(i_valid[i]);
        end
        o_total = w_run;
    end
endmodule

// File: rtl/fet_queue.sv
// Fetch-to-decode queue: compacts valid slots in order, 1-cycle enqueue-to-dequeue latency.
// enq_ready only when a full group fits; decode consumes 0..DECODE_WIDTH entries per cycle.
module fet_queue
    import fet_queue_pkg::*;
#(
    parameter int FETCH_WIDTH  = 4,
    parameter int DECODE_WIDTH = 2,
    parameter int DEPTH        = FETQ_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                enq_valid,
    output logic                                enq_ready,
    input  fet_bundle_t [FETCH_WIDTH-1:0]       enq_bundle,
    output logic [DECODE_WIDTH-1:0]             deq_valid,
    output fet_bundle_t [DECODE_WIDTH-1:0]      deq_bundle,
    input  logic [$clog2(DECODE_WIDTH+1)-1:0]   deq_num,
    output logic [$clog2(DEPTH+1)-1:0]          count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int OFF_W = $clog2(FETCH_WIDTH);
    localparam int TOT_W = $clog2(FETCH_WIDTH + 1);
    localparam logic [PTR_W:0] DEPTH_X = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] FW_X    = (PTR_W + 1)'(FETCH_WIDTH);

    logic [PTR_W-1:0]                 r_head;
    logic [PTR_W-1:0]                 r_tail;
    fet_bundle_t                      r_mem [DEPTH];
    logic [PTR_W-1:0]                 w_occ;
    logic [FETCH_WIDTH-1:0]           w_slot_vld;
    logic [FETCH_WIDTH-1:0][OFF_W-1:0] w_off;
    logic [TOT_W-1:0]                 w_total;
    logic [IDX_W-1:0]                 w_widx [FETCH_WIDTH];
    fet_bundle_t [FETCH_WIDTH-1:0]    w_wdat;
    logic                             w_enq_fire;

    // Pointers carry a wrap bit, so plain subtraction gives occupancy 0..DEPTH.
    assign w_occ      = r_tail - r_head;
    assign count      = w_occ;
    assign enq_ready  = ({1'b0, w_occ} + FW_X) <= DEPTH_X;
    assign w_enq_fire = enq_valid && enq_ready && !flush;

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_slot_vld[i] = enq_bundle[i].valid;
        end
    end

    fet_compact #(
        .WIDTH (FETCH_WIDTH),
        .OFF_W (OFF_W),
        .TOT_W (TOT_W)
    ) u_compact (
        .i_valid  (w_slot_vld),
        .o_offset (w_off),
        .o_total  (w_total)
    );

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_widx[i]       = r_tail[IDX_W-1:0] + IDX_W'(w_off[i]);
            w_wdat[i]       = enq_bundle[i];
            w_wdat[i].valid = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            deq_valid[i]  = w_occ > PTR_W'(i);
            deq_bundle[i] = deq_valid[i] ? r_mem[r_head[IDX_W-1:0] + IDX_W'(i)] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_enq_fire) begin
                for (int i = 0; i < FETCH_WIDTH; i++) begin
                    if (w_slot_vld[i]) r_mem[w_widx[i]] <= w_wdat[i];
                end
                r_tail <= r_tail + PTR_W'(w_total);
            end
            r_head <= r_head + PTR_W'(deq_num);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) {1'b0, w_occ} <= DEPTH_X);
endmodule

// File: tb/tb_fet_queue.sv
// Directed bench for fet_queue: reset, compaction, fill/backpressure, wrap, simultaneous enq/deq, flush.
module tb_fet_queue;
    import fet_queue_pkg::*;

    typedef fet_bundle_t [3:0] grp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   enq_valid;
    logic                   enq_ready;
    grp_t                   enq_bundle;
    logic [1:0]             deq_valid;
    fet_bundle_t [1:0]      deq_bundle;
    logic [1:0]             deq_num;
    logic [4:0]             count;

    int n_pass   = 0;
    int n_checks = 0;

    fet_queue #(.FETCH_WIDTH(4), .DECODE_WIDTH(2), .DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .enq_valid  (enq_valid),
        .enq_ready  (enq_ready),
        .enq_bundle (enq_bundle),
        .deq_valid  (deq_valid),
        .deq_bundle (deq_bundle),
        .deq_num    (deq_num),
        .count      (count)
    );

    always #5 clk = ~clk;

    a_deq_legal: assert property (@(posedge clk) disable iff (rst) {3'b0, deq_num} <= count);

    function automatic fet_bundle_t mk(input logic v, input logic [31:0] pc);
        fet_bundle_t b;
        b.valid = v;
        b.pc    = pc;
        b.inst  = ~pc;
        return b;
    endfunction

    function automatic grp_t grp(input logic [3:0] mask, input logic [31:0] base);
        grp_t g;
        for (int i = 0; i < 4; i++) g[i] = mk(mask[i], base + 32'(4 * i));
        return g;
    endfunction

    task automatic cycle(input logic ev, input grp_t g, input logic [1:0] dn, input logic fl);
        enq_valid  = ev;
        enq_bundle = g;
        deq_num    = dn;
        flush      = fl;
        @(posedge clk);
        #1;
        enq_valid  = 1'b0;
        enq_bundle = '0;
        deq_num    = 2'd0;
        flush      = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_bundle = '0; deq_num = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++; if (enq_ready !== 1'b1) $display("FAIL reset_enq_ready got %b exp 1", enq_ready); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
        n_checks++; if (deq_valid !== 2'b00) $display("FAIL reset_deq_valid got %b exp 00", deq_valid); else n_pass++;
        n_checks++; if (deq_bundle !== '0) $display("FAIL reset_deq_bundle got %h exp 0", deq_bundle); else n_pass++;
    endtask

    task automatic test_full_group;
        cycle(1'b1, grp(4'hF, 32'h1000), 2'd0, 1'b0);
        n_checks++; if (count !== 5'd4) $display("FAIL full_count got %0d exp 4", count); else n_pass++;
        n_checks++; if (deq_valid !== 2'b11) $display("FAIL full_deq_valid got %b exp 11", deq_valid); else n_pass++;
        n_checks++; if (deq_bundle[0] !== mk(1'b1, 32'h1000)) $display("FAIL full_slot0 got %h exp pc 1000", deq_bundle[0]); else n_pass++;
        n_checks++; if (deq_bundle[1] !== mk(1'b1, 32'h1004)) $display("FAIL full_slot1 got %h exp pc 1004", deq_bundle[1]); else n_pass++;
        n_checks++; if (enq_ready !== 1'b1) $display("FAIL full_enq_ready got %b exp 1", enq_ready); else n_pass++;
        cycle(1'b0, '0, 2'd2, 1'b0);
        n_checks++; if (count !== 5'd2) $display("FAIL deq2_count got %0d exp 2", count); else n_pass++;
        n_checks++; if (deq_bundle[0].pc !== 32'h1008) $display("FAIL deq2_slot0 got %h exp 1008", deq_bundle[0].pc); else n_pass++;
        n_checks++; if (deq_bundle[1].pc !== 32'h100C) $display("FAIL deq2_slot1 got %h exp 100c", deq_bundle[1].pc); else n_pass++;
        cycle(1'b0, '0, 2'd2, 1'b0);
        n_checks++; if (count !== 5'd0) $display("FAIL drain_count got %0d exp 0", count); else n_pass++;
        n_checks++; if (deq_valid !== 2'b00) $display("FAIL drain_deq_valid got %b exp 00", deq_valid); else n_pass++;
        n_checks++; if (deq_bundle[1] !== '0) $display("FAIL drain_slot1_zero got %h exp 0", deq_bundle[1]); else n_pass++;
    endtask

    task automatic test_holes;
        cycle(1'b1, grp(4'b1010, 32'h20), 2'd0, 1'b0);
        n_checks++; if (count !== 5'd2) $display("FAIL holes_count got %0d exp 2", count); else n_pass++;
        n_checks++; if (deq_bundle[0] !== mk(1'b1, 32'h24)) $display("FAIL holes_slot0 got %h exp pc 24", deq_bundle[0]); else n_pass++;
        n_checks++; if (deq_bundle[1] !== mk(1'b1, 32'h2C)) $display("FAIL holes_slot1 got %h exp pc 2c", deq_bundle[1]); else n_pass++;
        cycle(1'b0, '0, 2'd2, 1'b0);
        n_checks++; if (count !== 5'd0) $display("FAIL holes_drain got %0d exp 0", count); else n_pass++;
    endtask

    task automatic test_fill;
        cycle(1'b1, grp(4'hF, 32'h3000), 2'd0, 1'b0);
        cycle(1'b1, grp(4'hF, 32'h3010), 2'd0, 1'b0);
        cycle(1'b1, grp(4'hF, 32'h3020), 2'd0, 1'b0);
        cycle(1'b1, grp(4'b0001, 32'h3030), 2'd0, 1'b0);
        n_checks++; if (count !== 5'd13) $display("FAIL fill_count got %0d exp 13", count); else n_pass++;
        n_checks++; if (enq_ready !== 1'b0) $display("FAIL fill_enq_ready got %b exp 0", enq_ready); else n_pass++;
        cycle(1'b1, grp(4'hF, 32'h9000), 2'd0, 1'b0);
        n_checks++; if (count !== 5'd13) $display("FAIL blocked_count got %0d exp 13", count); else n_pass++;
        n_checks++; if (deq_bundle[0].pc !== 32'h3000) $display("FAIL fill_slot0 got %h exp 3000", deq_bundle[0].pc); else n_pass++;
        n_checks++; if (deq_bundle[1].pc !== 32'h3004) $display("FAIL fill_slot1 got %h exp 3004", deq_bundle[1].pc); else n_pass++;
        cycle(1'b0, '0, 2'd2, 1'b0);
        n_checks++; if (count !== 5'd11) $display("FAIL unblock_count got %0d exp 11", count); else n_pass++;
        n_checks++; if (enq_ready !== 1'b1) $display("FAIL unblock_enq_ready got %b exp 1", enq_ready); else n_pass++;
        for (int k = 2; k < 13; k += 2) begin
            n_checks++;
            if (deq_bundle[0].pc !== 32'h3000 + 32'(4 * k))
                $display("FAIL order_%0d got %h exp %h", k, deq_bundle[0].pc, 32'h3000 + 32'(4 * k));
            else n_pass++;
            if (k + 1 < 13) begin
                n_checks++;
                if (deq_bundle[1].pc !== 32'h3000 + 32'(4 * (k + 1)))
                    $display("FAIL order_%0d got %h exp %h", k + 1, deq_bundle[1].pc, 32'h3000 + 32'(4 * (k + 1)));
                else n_pass++;
            end
            cycle(1'b0, '0, (k + 1 < 13) ? 2'd2 : 2'd1, 1'b0);
        end
        n_checks++; if (count !== 5'd0) $display("FAIL fill_drain got %0d exp 0", count); else n_pass++;
    endtask

    task automatic test_wrap;
        cycle(1'b0, '0, 2'd0, 1'b1);
        cycle(1'b1, grp(4'hF, 32'h100), 2'd0, 1'b0);
        cycle(1'b1, grp(4'hF, 32'h110), 2'd0, 1'b0);
        cycle(1'b1, grp(4'hF, 32'h120), 2'd0, 1'b0);
        cycle(1'b1, grp(4'b0011, 32'h130), 2'd0, 1'b0);
        n_checks++; if (count !== 5'd14) $display("FAIL wrap_setup got %0d exp 14", count); else n_pass++;
        repeat (7) cycle(1'b0, '0, 2'd2, 1'b0);
        n_checks++; if (count !== 5'd0) $display("FAIL wrap_empty got %0d exp 0", count); else n_pass++;
        cycle(1'b1, grp(4'hF, 32'h5000), 2'd0, 1'b0);
        n_checks++; if (count !== 5'd4) $display("FAIL wrap_count got %0d exp 4", count); else n_pass++;
        n_checks++; if (deq_bundle[0].pc !== 32'h5000) $display("FAIL wrap_slot0 got %h exp 5000", deq_bundle[0].pc); else n_pass++;
        n_checks++; if (deq_bundle[1].pc !== 32'h5004) $display("FAIL wrap_slot1 got %h exp 5004", deq_bundle[1].pc); else n_pass++;
        cycle(1'b0, '0, 2'd2, 1'b0);
        n_checks++; if (count !== 5'd2) $display("FAIL wrap_after_deq got %0d exp 2", count); else n_pass++;
        n_checks++; if (deq_bundle[0].pc !== 32'h5008) $display("FAIL wrap_idx0 got %h exp 5008", deq_bundle[0].pc); else n_pass++;
        n_checks++; if (deq_bundle[1].pc !== 32'h500C) $display("FAIL wrap_idx1 got %h exp 500c", deq_bundle[1].pc); else n_pass++;
    endtask

    task automatic test_back_to_back;
        cycle(1'b1, grp(4'b0101, 32'h6000), 2'd2, 1'b0);
        n_checks++; if (count !== 5'd2) $display("FAIL b2b_count got %0d exp 2", count); else n_pass++;
        n_checks++; if (deq_bundle[0].pc !== 32'h6000) $display("FAIL b2b_slot0 got %h exp 6000", deq_bundle[0].pc); else n_pass++;
        n_checks++; if (deq_bundle[1].pc !== 32'h6008) $display("FAIL b2b_slot1 got %h exp 6008", deq_bundle[1].pc); else n_pass++;
    endtask

    task automatic test_flush;
        cycle(1'b1, grp(4'hF, 32'h7000), 2'd0, 1'b0);
        n_checks++; if (count !== 5'd6) $display("FAIL preflush_count got %0d exp 6", count); else n_pass++;
        cycle(1'b1, grp(4'hF, 32'h8000), 2'd2, 1'b1);
        n_checks++; if (count !== 5'd0) $display("FAIL flush_count got %0d exp 0", count); else n_pass++;
        n_checks++; if (deq_valid !== 2'b00) $display("FAIL flush_deq_valid got %b exp 00", deq_valid); else n_pass++;
        n_checks++; if (enq_ready !== 1'b1) $display("FAIL flush_enq_ready got %b exp 1", enq_ready); else n_pass++;
        cycle(1'b0, '0, 2'd0, 1'b0);
        n_checks++; if (count !== 5'd0) $display("FAIL flush_idle got %0d exp 0", count); else n_pass++;
        cycle(1'b1, grp(4'b0001, 32'hA000), 2'd0, 1'b0);
        n_checks++; if (deq_valid !== 2'b01) $display("FAIL postflush_valid got %b exp 01", deq_valid); else n_pass++;
        n_checks++; if (deq_bundle[0].pc !== 32'hA000) $display("FAIL postflush_slot0 got %h exp a000", deq_bundle[0].pc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_group();
        test_holes();
        test_fill();
        test_wrap();
        test_back_to_back();
        test_flush();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
